// File: rtl/zbt_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// zbt_bank_arbiter_if
//   Bundles every signal of the ZBT bank arbiter except clk/reset.
//   Groups:
//     display read port : rd_req, rd_addr, rd_ready, rd_data, rd_valid
//     pixel write port  : wr_req, wr_addr, wr_data, wr_ready, wr_drop,
//                         fifo_level
//     ZBT bank side     : zbt_addr, zbt_we, zbt_write_data, zbt_read_data
//   Modports:
//     slave  - the arbiter itself
//     master - the surrounding logic (requesters and SRAM driver)
// ---------------------------------------------------------------------------
interface zbt_bank_arbiter_if #(
   parameter int DEPTH = 4
) ();
   localparam int LVL_W = $clog2(DEPTH) + 1;

   // display read port
   logic              rd_req;
   logic [18:0]       rd_addr;
   logic              rd_ready;
   logic [35:0]       rd_data;
   logic              rd_valid;

   // pixel-processor write port
   logic              wr_req;
   logic [18:0]       wr_addr;
   logic [35:0]       wr_data;
   logic              wr_ready;
   logic              wr_drop;
   logic [LVL_W-1:0]  fifo_level;

   // ZBT bank side
   logic [18:0]       zbt_addr;
   logic              zbt_we;
   logic [35:0]       zbt_write_data;
   logic [35:0]       zbt_read_data;

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, zbt_read_data,
      output rd_ready, rd_data, rd_valid, wr_ready, wr_drop, fifo_level,
             zbt_addr, zbt_we, zbt_write_data
   );

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, zbt_read_data,
      input  rd_ready, rd_data, rd_valid, wr_ready, wr_drop, fifo_level,
             zbt_addr, zbt_we, zbt_write_data
   );
endinterface

// File: rtl/zbt_bank_arbiter.sv
// ---------------------------------------------------------------------------
// zbt_bank_arbiter
//   Shares one ZBT SRAM bank between a display read port and a pixel
//   processor write port. Reads win arbitration; writes are parked in a small
//   FIFO and drained whenever no read is granted. A read-streak limiter forces
//   a write slot after MAX_RD_STREAK consecutive reads with writes pending.
//   At most one SRAM operation is issued per clock.
//
// Parameters:
//   DEPTH         write FIFO depth (power of two, >= 2)
//   READ_LAT      SRAM cycles from zbt_addr to zbt_read_data
//   MAX_RD_STREAK reads allowed in a row while writes are waiting
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    zbt_bank_arbiter_if.slave:
//            rd_req/rd_addr in, rd_ready (comb) / rd_data / rd_valid out
//            wr_req/wr_addr/wr_data in, wr_ready / wr_drop / fifo_level out
//            zbt_addr / zbt_we / zbt_write_data out, zbt_read_data in
// ---------------------------------------------------------------------------
module zbt_bank_arbiter #(
   parameter int DEPTH         = 4,
   parameter int READ_LAT      = 2,
   parameter int MAX_RD_STREAK = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   zbt_bank_arbiter_if.slave      bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int SW = $clog2(MAX_RD_STREAK + 1);
   localparam int PW = READ_LAT + 1;

   // FIFO storage (datapath, never reset: pointers define validity)
   logic [18:0]    fifo_addr_q [DEPTH];
   logic [35:0]    fifo_data_q [DEPTH];

   // control state
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW-1:0]  rptr_q, rptr_d;
   logic [LW-1:0]  level_q, level_d;
   logic [SW-1:0]  streak_q, streak_d;
   logic           wr_ready_q, wr_ready_d;
   logic           wr_drop_q, wr_drop_d;
   logic [PW-1:0]  rd_pipe_q, rd_pipe_d;

   // registered outputs
   logic [18:0]    zbt_addr_q, zbt_addr_d;
   logic           zbt_we_q, zbt_we_d;
   logic [35:0]    zbt_wd_q, zbt_wd_d;
   logic [35:0]    rd_data_q, rd_data_d;
   logic           rd_valid_q, rd_valid_d;

   // arbitration
   logic           fifo_empty;
   logic           grant_rd;
   logic           grant_wr;
   logic           push;
   logic           pop;

   // ------------------------------------------------------------------
   // Grant decision. Reads win unless writes have waited through a full
   // streak of reads.
   // ------------------------------------------------------------------
   always_comb begin
      fifo_empty = (level_q == '0);
      grant_rd   = bus.rd_req && (fifo_empty || (streak_q < SW'(MAX_RD_STREAK)));
      grant_wr   = !grant_rd && !fifo_empty;
      // wr_ready is the registered view of level, so a same-cycle pop never
      // opens an extra push slot.
      push       = bus.wr_req && wr_ready_q;
      pop        = grant_wr;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d     = pop  ? rptr_q + AW'(1) : rptr_q;

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      wr_ready_d = (level_d < LW'(DEPTH));
      wr_drop_d  = bus.wr_req && !wr_ready_q;

      // Streak only counts reads that overtook pending writes.
      if (fifo_empty || grant_wr) begin
         streak_d = '0;
      end else if (grant_rd && (streak_q < SW'(MAX_RD_STREAK))) begin
         streak_d = streak_q + SW'(1);
      end else begin
         streak_d = streak_q;
      end

      // Idle cycles keep address/data stable to avoid needless bus toggling.
      zbt_addr_d = zbt_addr_q;
      zbt_wd_d   = zbt_wd_q;
      zbt_we_d   = 1'b0;
      if (grant_rd) begin
         zbt_addr_d = bus.rd_addr;
      end else if (grant_wr) begin
         zbt_addr_d = fifo_addr_q[rptr_q];
         zbt_wd_d   = fifo_data_q[rptr_q];
         zbt_we_d   = 1'b1;
      end

      // Bit k set means a read address has been on the bus for k+1 cycles;
      // the top bit lines up with the SRAM presenting its data.
      rd_pipe_d  = PW'({rd_pipe_q, grant_rd});
      rd_valid_d = rd_pipe_q[PW-1];
      rd_data_d  = rd_pipe_q[PW-1] ? bus.zbt_read_data : rd_data_q;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         streak_q   <= '0;
         wr_ready_q <= 1'b1;
         wr_drop_q  <= 1'b0;
         rd_pipe_q  <= '0;
         zbt_addr_q <= '0;
         zbt_we_q   <= 1'b0;
         zbt_wd_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         streak_q   <= streak_d;
         wr_ready_q <= wr_ready_d;
         wr_drop_q  <= wr_drop_d;
         rd_pipe_q  <= rd_pipe_d;
         zbt_addr_q <= zbt_addr_d;
         zbt_we_q   <= zbt_we_d;
         zbt_wd_q   <= zbt_wd_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wptr_q] <= bus.wr_addr;
         fifo_data_q[wptr_q] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (level_q <= LW'(DEPTH));
         assert (!(push && (level_q == LW'(DEPTH))));
         assert (!(pop && fifo_empty));
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.rd_ready       = grant_rd;
   assign bus.rd_data        = rd_data_q;
   assign bus.rd_valid       = rd_valid_q;
   assign bus.wr_ready       = wr_ready_q;
   assign bus.wr_drop        = wr_drop_q;
   assign bus.fifo_level     = level_q;
   assign bus.zbt_addr       = zbt_addr_q;
   assign bus.zbt_we         = zbt_we_q;
   assign bus.zbt_write_data = zbt_wd_q;

endmodule

// File: tb/tb_zbt_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_zbt_bank_arbiter
//   Directed scenarios followed by randomized traffic. A stimulus process
//   drives each cycle, steps a queue-based reference model and pushes the
//   expected outputs; a monitor process pops and compares at the falling
//   edge. A small SRAM model answers reads READ_LAT cycles after the
//   address appears.
// ---------------------------------------------------------------------------
module tb_zbt_bank_arbiter;
   localparam int DEPTH = 4;
   localparam int RL    = 2;
   localparam int MAXS  = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   zbt_bank_arbiter_if #(.DEPTH(DEPTH)) bus ();

   zbt_bank_arbiter #(
      .DEPTH(DEPTH), .READ_LAT(RL), .MAX_RD_STREAK(MAXS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // SRAM contents are a fixed function of the address
   function automatic logic [35:0] sram_f(input logic [18:0] a);
      if (a == 19'h00123) return 36'hABCDE1234;
      return {a[16:0] ^ 17'h15A5A, a};
   endfunction

   logic [18:0] apipe [RL];
   always @(posedge clk) begin
      apipe[0] <= bus.zbt_addr;
      for (int k = 1; k < RL; k++) apipe[k] <= apipe[k-1];
   end
   assign bus.zbt_read_data = sram_f(apipe[RL-1]);

   typedef struct {
      int          cyc;
      logic        chk;
      logic        rd_ready;
      logic [18:0] zaddr;
      logic        zwe;
      logic [35:0] zwd;
      logic        rd_valid;
      logic [35:0] rd_data;
      logic        wr_ready;
      logic        wr_drop;
      int          level;
   } cyc_exp_t;
   typedef struct { int due; logic [35:0] data; } ret_t;
   typedef struct { logic [18:0] addr; logic [35:0] data; } wr_t;

   cyc_exp_t exp_q [$];
   ret_t     ret_q [$];
   wr_t      wr_q  [$];

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   wr_t         m_fifo [$];
   ret_t        m_pend [$];
   int          m_streak = 0;
   int          m_cyc    = -1;
   logic        m_known  = 1'b0;
   logic [18:0] m_zaddr  = '0;
   logic        m_zwe    = 1'b0;
   logic [35:0] m_zwd    = '0;
   logic [35:0] m_rdata  = '0;
   logic        m_wdrop  = 1'b0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endfunction

   task automatic step(input logic rst, input logic rq, input logic [18:0] ra,
                       input logic wq, input logic [18:0] wa, input logic [35:0] wd);
      cyc_exp_t e;
      ret_t     r;
      wr_t      w;
      int       lvl;
      logic     empty, g_rd, g_wr;
      @(posedge clk);
      #1;
      reset       = rst;
      bus.rd_req  = rq;
      bus.rd_addr = ra;
      bus.wr_req  = wq;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      m_cyc++;
      lvl   = m_fifo.size();
      empty = (lvl == 0);
      g_rd  = rq && (empty || m_streak < MAXS);
      g_wr  = !g_rd && !empty;
      e.cyc      = m_cyc;
      e.chk      = m_known;
      e.rd_ready = g_rd;
      e.zaddr    = m_zaddr;
      e.zwe      = m_zwe;
      e.zwd      = m_zwd;
      e.wr_ready = (lvl < DEPTH);
      e.wr_drop  = m_wdrop;
      e.level    = lvl;
      e.rd_valid = 1'b0;
      if (m_pend.size() > 0 && m_pend[0].due == m_cyc) begin
         e.rd_valid = 1'b1;
         m_rdata    = m_pend[0].data;
         void'(m_pend.pop_front());
      end
      e.rd_data = m_rdata;
      exp_q.push_back(e);
      if (rst) begin
         m_fifo.delete();
         m_pend.delete();
         while (ret_q.size() > 0 && ret_q[ret_q.size()-1].due > m_cyc) void'(ret_q.pop_back());
         m_streak = 0;
         m_zaddr  = '0;
         m_zwe    = 1'b0;
         m_zwd    = '0;
         m_rdata  = '0;
         m_wdrop  = 1'b0;
         m_known  = 1'b1;
      end else begin
         if (g_rd) begin
            m_zaddr = ra;
            m_zwe   = 1'b0;
            r.due   = m_cyc + 2 + RL;
            r.data  = sram_f(ra);
            m_pend.push_back(r);
            ret_q.push_back(r);
         end else if (g_wr) begin
            w       = m_fifo.pop_front();
            m_zaddr = w.addr;
            m_zwd   = w.data;
            m_zwe   = 1'b1;
            wr_q.push_back(w);
         end else begin
            m_zwe = 1'b0;
         end
         if (empty || g_wr) m_streak = 0;
         else if (g_rd && m_streak < MAXS) m_streak++;
         m_wdrop = wq && !(lvl < DEPTH);
         if (wq && lvl < DEPTH) m_fifo.push_back('{addr: wa, data: wd});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, '0);
   endtask

   // monitor: compares everything the DUT presents against the queues
   initial begin : monitor
      cyc_exp_t e;
      ret_t     r;
      wr_t      w;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) continue;
         e = exp_q.pop_front();
         if (!e.chk) continue;
         chk("rd_ready",       64'(bus.rd_ready),       64'(e.rd_ready));
         chk("zbt_addr",       64'(bus.zbt_addr),       64'(e.zaddr));
         chk("zbt_we",         64'(bus.zbt_we),         64'(e.zwe));
         chk("zbt_write_data", 64'(bus.zbt_write_data), 64'(e.zwd));
         chk("rd_valid",       64'(bus.rd_valid),       64'(e.rd_valid));
         chk("rd_data",        64'(bus.rd_data),        64'(e.rd_data));
         chk("wr_ready",       64'(bus.wr_ready),       64'(e.wr_ready));
         chk("wr_drop",        64'(bus.wr_drop),        64'(e.wr_drop));
         chk("fifo_level",     64'(bus.fifo_level),     64'(e.level));
         if (bus.rd_valid === 1'b1) begin
            if (ret_q.size() == 0) begin
               chk("rd_valid_unexpected", 64'(bus.rd_valid), 64'(0));
            end else begin
               r = ret_q.pop_front();
               chk("rd_return_data",  64'(bus.rd_data), 64'(r.data));
               chk("rd_return_cycle", 64'(e.cyc),       64'(r.due));
            end
         end
         if (bus.zbt_we === 1'b1) begin
            if (wr_q.size() == 0) begin
               chk("zbt_we_unexpected", 64'(bus.zbt_we), 64'(0));
            end else begin
               w = wr_q.pop_front();
               chk("write_order_addr", 64'(bus.zbt_addr),       64'(w.addr));
               chk("write_order_data", 64'(bus.zbt_write_data), 64'(w.data));
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int          rd_pct, wr_pct;
      logic        rst, rq, wq;
      logic [18:0] ra, wa;
      logic [35:0] wd;
      reset       = 1'b1;
      bus.rd_req  = 1'b0;
      bus.rd_addr = '0;
      bus.wr_req  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;

      // reset, then a single read in cycle 2
      step(1'b1, 1'b0, '0, 1'b0, '0, '0);
      step(1'b1, 1'b0, '0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 19'h00123, 1'b0, '0, '0);
      idle(6);

      // single write at the top address
      step(1'b0, 1'b0, '0, 1'b1, 19'h7FFFF, 36'h3FFFF0000);
      idle(4);

      // streak limit: continuous reads with one write queued
      for (int i = 0; i < MAXS + 6; i++)
         step(1'b0, 1'b1, 19'(16'h100 + i), (i == 0), 19'h05555, 36'h123456789);
      idle(6);

      // overflow: reads held high, six consecutive writes
      for (int i = 0; i < 20; i++)
         step(1'b0, 1'b1, 19'(16'h200 + i), (i < 6), 19'(16'h300 + i), 36'(64'hA00000000 + i));
      idle(8);

      // back-to-back reads, reset two cycles after the last grant
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 19'(16'h400 + i), 1'b0, '0, '0);
      idle(1);
      step(1'b1, 1'b0, '0, 1'b0, '0, '0);
      idle(6);

      // simultaneous push and pop with two entries queued
      step(1'b0, 1'b1, 19'h00500, 1'b1, 19'h00601, 36'h111111111);
      step(1'b0, 1'b1, 19'h00501, 1'b1, 19'h00602, 36'h222222222);
      step(1'b0, 1'b1, 19'h00502, 1'b0, '0, '0);
      step(1'b0, 1'b0, '0, 1'b1, 19'h00603, 36'h333333333);
      idle(6);

      // randomized traffic with occasional resets
      rd_pct = 50;
      wr_pct = 50;
      for (int i = 0; i < 2000; i++) begin
         if (i % 250 == 0) begin
            rd_pct = $urandom_range(0, 100);
            wr_pct = $urandom_range(0, 100);
         end
         rst = ($urandom_range(0, 299) == 0);
         rq  = !rst && ($urandom_range(0, 99) < rd_pct);
         wq  = !rst && ($urandom_range(0, 99) < wr_pct);
         ra  = 19'($urandom);
         wa  = 19'($urandom);
         wd  = {4'($urandom), 32'($urandom)};
         step(rst, rq, ra, wq, wa, wd);
      end
      idle(12);
      @(negedge clk);
      #1;
      chk("reads_outstanding",  64'(ret_q.size()), 64'(0));
      chk("writes_outstanding", 64'(wr_q.size()),  64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
